// File: rtl/triangle_pwm_pkg.sv
// rtl/triangle_pwm_pkg.sv - shared types and constants for the triangle PWM fader
package triangle_pwm_pkg;

    typedef enum logic {
        S_UP   = 1'b0,
        S_DOWN = 1'b1
    } tri_state_t;

    localparam logic [31:0] TRI_RST_DUTY = '0;

endpackage

// File: rtl/adder_n.sv
// rtl/adder_n.sv - N-bit modular adder, carry discarded
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/comparator_eq.sv
// rtl/comparator_eq.sv - N-bit equality comparator
module comparator_eq #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);

    assign eq = (a == b);

endmodule

// File: rtl/triangle_pwm_pwm_core.sv
// rtl/triangle_pwm_pwm_core.sv - free-running PWM counter and compare; TRIANGLE_PWM_SHADOW_EN latches duty only at period wrap
module pwm_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] duty,
    output logic         pwm_out
);

    logic [N-1:0] pwm_cnt;
    logic [N-1:0] cmp;

`ifdef TRIANGLE_PWM_SHADOW_EN
    // Duty is only picked up on the last count, so a period always runs to completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmp <= '0;
        end else if (ena && (pwm_cnt == '1)) begin
            cmp <= duty;
        end
    end
`else
    assign cmp = duty;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= ena & (pwm_cnt < cmp);
            if (ena) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/triangle_pwm.sv
// rtl/triangle_pwm.sv - step-driven triangle duty ramp feeding a PWM core; TRIANGLE_PWM_SHADOW_EN selects glitch-free compare
module triangle_pwm
    import triangle_pwm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic [N-1:0] max_duty,
    output logic [N-1:0] duty,
    output logic         dir,
    output logic         period_done,
    output logic         pwm_out
);

    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ALL_ONES = '1;

    tri_state_t   state;
    logic         accept;
    logic [N-1:0] duty_inc;
    logic [N-1:0] duty_dec;
    logic         inc_hits_max;
    logic         at_one;

    assign accept = step & ena;
    assign dir    = (state == S_DOWN);

    adder_n #(.N(N)) u_inc (
        .a   (duty),
        .b   (ONE),
        .sum (duty_inc)
    );

    // Adding all-ones is a decrement; it is only used when duty is nonzero.
    adder_n #(.N(N)) u_dec (
        .a   (duty),
        .b   (ALL_ONES),
        .sum (duty_dec)
    );

    comparator_eq #(.N(N)) u_eq_max (
        .a  (duty_inc),
        .b  (max_duty),
        .eq (inc_hits_max)
    );

    comparator_eq #(.N(N)) u_eq_one (
        .a  (duty),
        .b  (ONE),
        .eq (at_one)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_UP;
            duty        <= TRI_RST_DUTY[N-1:0];
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;
            if (accept) begin
                case (state)
                    S_UP: begin
                        // A peak lowered below the current duty turns the ramp without moving duty.
                        if (duty < max_duty) begin
                            duty <= duty_inc;
                            if (inc_hits_max) begin
                                state <= S_DOWN;
                            end
                        end else begin
                            state <= S_DOWN;
                        end
                    end
                    S_DOWN: begin
                        if (duty != '0) begin
                            duty <= duty_dec;
                            if (at_one) begin
                                state       <= S_UP;
                                period_done <= 1'b1;
                            end
                        end else begin
                            state <= S_UP;
                        end
                    end
                    default: state <= S_UP;
                endcase
            end
        end
    end

    pwm_core #(.N(N)) u_pwm_core (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .duty    (duty),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_triangle_pwm.sv
// tb/tb_triangle_pwm.sv - self-checking bench for triangle_pwm with a cycle model
module tb_triangle_pwm;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       step;
    logic [7:0] max_duty;
    logic [7:0] duty;
    logic       dir;
    logic       period_done;
    logic       pwm_out;

    int passed = 0;
    int total  = 0;

    triangle_pwm #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .step        (step),
        .max_duty    (max_duty),
        .duty        (duty),
        .dir         (dir),
        .period_done (period_done),
        .pwm_out     (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the outputs, advanced from the rules on every rising edge
    int m_duty, m_cnt, m_cmp, nd;
    bit m_dir, m_pwm, m_pd, m_valid, ndir;
    int cmp_eff;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_duty = 0; m_dir = 0; m_cnt = 0; m_cmp = 0;
            m_pwm = 0;  m_pd = 0;  m_valid = 1;
        end else begin
            nd = m_duty; ndir = m_dir; m_pd = 0;
            if (ena && step) begin
                if (!m_dir) begin
                    if (m_duty < int'(max_duty)) begin
                        nd = m_duty + 1;
                        if (nd == int'(max_duty)) ndir = 1;
                    end else ndir = 1;
                end else begin
                    if (m_duty > 0) begin
                        nd = m_duty - 1;
                        if (nd == 0) begin ndir = 0; m_pd = 1; end
                    end else ndir = 0;
                end
            end
`ifdef TRIANGLE_PWM_SHADOW_EN
            cmp_eff = m_cmp;
            if (ena && m_cnt == 255) m_cmp = m_duty;
`else
            cmp_eff = m_duty;
`endif
            m_pwm = ena && (m_cnt < cmp_eff);
            if (ena) m_cnt = (m_cnt + 1) % 256;
            m_duty = nd;
            m_dir  = ndir;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_duty", 32'(duty), 32'(m_duty));
            chk("cyc_dir", 32'(dir), 32'(m_dir));
            chk("cyc_period_done", 32'(period_done), 32'(m_pd));
            chk("cyc_pwm_out", 32'(pwm_out), 32'(m_pwm));
        end
    end

    int pwm_hi = 0;
    int pd_seen = 0;
    always @(negedge clk) begin
        if (pwm_out === 1'b1) pwm_hi++;
        if (period_done === 1'b1) pd_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    int exp_t1[7] = '{1, 2, 3, 2, 1, 0, 1};
    int hi1, hi2;

    initial begin
        rst = 1'b0; ena = 1'b1; step = 1'b0; max_duty = 8'd0;
        tick(); tick();
        chk("rst_duty", 32'(duty), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_period_done", 32'(period_done), 0);
        chk("rst_pwm_out", 32'(pwm_out), 0);
        rst = 1'b1;

        // Test 1: small triangle, one step every 4 cycles
        max_duty = 8'd3;
        tick();
        pd_seen = 0;
        for (int i = 0; i < 7; i++) begin
            do_step();
            chk($sformatf("t1_duty%0d", i), 32'(duty), 32'(exp_t1[i]));
            if (i == 2) chk("t1_dir_at_peak", 32'(dir), 1);
            if (i == 5) chk("t1_period_done", 32'(period_done), 1);
            repeat (3) tick();
        end
        chk("t1_pd_count", 32'(pd_seen), 1);

        // Test 2: zero peak
        do_reset();
        max_duty = 8'd0;
        pwm_hi = 0; pd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            do_step();
            tick();
        end
        chk("t2_duty", 32'(duty), 0);
        chk("t2_pwm_hi", 32'(pwm_hi), 0);
        chk("t2_pd_count", 32'(pd_seen), 0);

        // Test 3: duty held at 64 for a full period
        do_reset();
        max_duty = 8'd64;
        step = 1'b1;
        repeat (64) tick();
        step = 1'b0;
        chk("t3_duty", 32'(duty), 64);
        chk("t3_dir", 32'(dir), 1);
        repeat (300) tick();
        pwm_hi = 0;
        repeat (256) tick();
        chk("t3_pwm_hi", 32'(pwm_hi), 64);

`ifdef TRIANGLE_PWM_SHADOW_EN
        do_reset();
        max_duty = 8'd200;
        step = 1'b1;
        repeat (64) tick();
        step = 1'b0;
        repeat (300) tick();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_cnt == 1) break;
        end
        hi1 = 0; hi2 = 0;
        for (int i = 0; i < 512; i++) begin
            if (i > 0) @(negedge clk);
            if (pwm_out === 1'b1) begin
                if (i < 256) hi1++; else hi2++;
            end
            step = (i >= 100 && i < 164);
        end
        step = 1'b0;
        chk("t3s_duty", 32'(duty), 128);
        chk("t3s_period_old", 32'(hi1), 64);
        chk("t3s_period_new", 32'(hi2), 128);
        tick();
`endif

        // Test 4: peak lowered below current duty
        do_reset();
        max_duty = 8'd10;
        for (int i = 0; i < 7; i++) begin
            do_step();
            tick();
        end
        chk("t4_duty7", 32'(duty), 7);
        chk("t4_dir_up", 32'(dir), 0);
        max_duty = 8'd4;
        do_step();
        chk("t4_turn_dir", 32'(dir), 1);
        chk("t4_turn_duty", 32'(duty), 7);
        do_step();
        chk("t4_duty6", 32'(duty), 6);
        do_step();
        chk("t4_duty5", 32'(duty), 5);

        // Test 5: disabled with step pulses
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step = (i % 4 == 0);
            tick();
            if (i == 0) pwm_hi = 0;
        end
        step = 1'b0;
        chk("t5_duty_held", 32'(duty), 5);
        chk("t5_dir_held", 32'(dir), 1);
        chk("t5_pwm_hi", 32'(pwm_hi), 0);
        ena = 1'b1;
        do_step();
        chk("t5_resume", 32'(duty), 4);
        repeat (300) tick();

        // Test 6: reset while ramping down at duty 5
        do_reset();
        max_duty = 8'd5;
        for (int i = 0; i < 5; i++) begin
            do_step();
            tick();
        end
        chk("t6_pre_duty", 32'(duty), 5);
        chk("t6_pre_dir", 32'(dir), 1);
        rst = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("t6_duty", 32'(duty), 0);
        chk("t6_dir", 32'(dir), 0);
        chk("t6_pwm_out", 32'(pwm_out), 0);
        chk("t6_period_done", 32'(period_done), 0);
        rst = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
